// File: rtl/sample_exerciser.sv
// Stimulus generator and response checker: issues N vectors (counter or LFSR),
// compares the downstream gate responses and reports errors and the first failing index.
module sample_exerciser (
    input  logic        clk_c1,
    input  logic        rstn_i1,
    input  logic        start_i1,
    input  logic        mode_i1,
    input  logic [15:0] count_i1,
    input  logic [6:0]  resp_i1,
    output logic [12:0] stim_o1,
    output logic        busy_o1,
    output logic        done_o1,
    output logic        pass_o1,
    output logic [7:0]  err_cnt_o1,
    output logic [15:0] first_fail_o1
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] NO_FAIL   = 16'hFFFF;

    state_t      state_reg;
    logic        mode_reg;
    logic [15:0] count_reg;
    logic [15:0] idx_reg;
    logic [15:0] lfsr_reg;
    logic        prev12_reg;
    logic [12:0] stim_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        pass_reg;
    logic [7:0]  err_reg;
    logic [15:0] first_fail_reg;

    logic [15:0] lfsr_next;
    logic [15:0] idx_next;
    logic [12:0] vec_next;
    logic [5:0]  exp_resp;
    logic        comb_fail;
    logic        dff_fail;
    logic [15:0] fail_idx;
    logic [7:0]  err_next;
    logic [15:0] first_fail_next;
    logic        last_vec;

    always_comb begin
        lfsr_next = {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5], lfsr_reg[15:1]};
        idx_next  = idx_reg + 16'd1;
        vec_next  = mode_reg ? lfsr_next[12:0] : idx_next[12:0];
        last_vec  = (idx_reg == count_reg - 16'd1);

        exp_resp[0] = stim_reg[0] & stim_reg[1];
        exp_resp[1] = stim_reg[2] | stim_reg[3];
        exp_resp[2] = stim_reg[4] ^ stim_reg[5];
        exp_resp[3] = ~stim_reg[6];
        exp_resp[4] = stim_reg[7] ? stim_reg[8] : stim_reg[9];
        exp_resp[5] = stim_reg[10] ^ stim_reg[11];

        comb_fail = (state_reg == RUN) && (resp_i1[5:0] != exp_resp);
        // The registered response lags one vector; nothing valid to compare on vector 0.
        dff_fail  = (((state_reg == RUN) && (idx_reg != 16'd0)) || (state_reg == DRAIN))
                    && (resp_i1[6] != prev12_reg);

        // A dff failure in RUN belongs to the previous vector, which is the lower index.
        fail_idx = ((state_reg == RUN) && dff_fail) ? idx_reg - 16'd1 : idx_reg;

        err_next        = err_reg;
        first_fail_next = first_fail_reg;
        if (comb_fail || dff_fail) begin
            if (err_reg != 8'hFF)
                err_next = err_reg + 8'd1;
            if (first_fail_reg == NO_FAIL)
                first_fail_next = fail_idx;
        end
    end

    always_ff @(posedge clk_c1) begin
        if (!rstn_i1) begin
            state_reg      <= IDLE;
            mode_reg       <= 1'b0;
            count_reg      <= 16'd0;
            idx_reg        <= 16'd0;
            lfsr_reg       <= LFSR_SEED;
            prev12_reg     <= 1'b0;
            stim_reg       <= 13'd0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            pass_reg       <= 1'b0;
            err_reg        <= 8'd0;
            first_fail_reg <= NO_FAIL;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start_i1) begin
                        mode_reg       <= mode_i1;
                        count_reg      <= count_i1;
                        idx_reg        <= 16'd0;
                        lfsr_reg       <= LFSR_SEED;
                        prev12_reg     <= 1'b0;
                        err_reg        <= 8'd0;
                        first_fail_reg <= NO_FAIL;
                        if (count_i1 != 16'd0) begin
                            state_reg <= RUN;
                            busy_reg  <= 1'b1;
                            done_reg  <= 1'b0;
                            pass_reg  <= 1'b0;
                            stim_reg  <= mode_i1 ? LFSR_SEED[12:0] : 13'd0;
                        end else begin
                            state_reg <= DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            pass_reg  <= 1'b1;
                            stim_reg  <= 13'd0;
                        end
                    end
                end
                RUN: begin
                    err_reg        <= err_next;
                    first_fail_reg <= first_fail_next;
                    prev12_reg     <= stim_reg[12];
                    if (last_vec) begin
                        state_reg <= DRAIN;
                    end else begin
                        idx_reg  <= idx_next;
                        stim_reg <= vec_next;
                        if (mode_reg)
                            lfsr_reg <= lfsr_next;
                    end
                end
                DRAIN: begin
                    err_reg        <= err_next;
                    first_fail_reg <= first_fail_next;
                    state_reg      <= DONE;
                    busy_reg       <= 1'b0;
                    done_reg       <= 1'b1;
                    pass_reg       <= (err_next == 8'd0);
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign stim_o1       = stim_reg;
    assign busy_o1       = busy_reg;
    assign done_o1       = done_reg;
    assign pass_o1       = pass_reg;
    assign err_cnt_o1    = err_reg;
    assign first_fail_o1 = first_fail_reg;

endmodule

// File: tb/tb_sample_exerciser.sv
// Directed bench for sample_exerciser: a gate-level response model with injectable
// faults sits downstream of the stimulus port.
module tb_sample_exerciser;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        mode;
    logic [15:0] count;
    logic [6:0]  resp;
    logic [12:0] stim;
    logic        busy;
    logic        done;
    logic        pass;
    logic [7:0]  err_cnt;
    logic [15:0] first_fail;

    logic dff_q;
    logic fault_and_s0, fault_mux0, fault_dff0, fault_dff1;

    int checks = 0;
    int errors = 0;
    int busy_cycles;
    logic [12:0] stim_log [0:15];

    always #5 clk = ~clk;

    sample_exerciser dut (
        .clk_c1        (clk),
        .rstn_i1       (rstn),
        .start_i1      (start),
        .mode_i1       (mode),
        .count_i1      (count),
        .resp_i1       (resp),
        .stim_o1       (stim),
        .busy_o1       (busy),
        .done_o1       (done),
        .pass_o1       (pass),
        .err_cnt_o1    (err_cnt),
        .first_fail_o1 (first_fail)
    );

    // Downstream gates; the dff captures stim[12] every clock.
    always_ff @(posedge clk) dff_q <= stim[12];

    always_comb begin
        resp    = '0;
        resp[0] = fault_and_s0 ? stim[0] : (stim[0] & stim[1]);
        resp[1] = stim[2] | stim[3];
        resp[2] = stim[4] ^ stim[5];
        resp[3] = ~stim[6];
        resp[4] = fault_mux0 ? 1'b0 : (stim[7] ? stim[8] : stim[9]);
        resp[5] = stim[10] ^ stim[11];
        resp[6] = fault_dff0 ? 1'b0 : (fault_dff1 ? 1'b1 : dff_q);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run(input logic m, input logic [15:0] n);
        @(negedge clk);
        mode  = m;
        count = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cycles = 0;
        while (busy && busy_cycles < 70000) begin
            if (busy_cycles < 16)
                stim_log[busy_cycles] = stim;
            busy_cycles++;
            @(negedge clk);
        end
        if (busy)
            check("busy_timeout", 32'(busy), 32'd0);
        $display("run mode=%0d n=%0d busy_cycles=%0d done=%0d pass=%0d err=%0d first_fail=%0h",
                 m, n, busy_cycles, done, pass, err_cnt, first_fail);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_stim"}, 32'(stim), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
        check({tag, "_pass"}, 32'(pass), 32'h0);
        check({tag, "_err"},  32'(err_cnt), 32'h0);
        check({tag, "_ff"},   32'(first_fail), 32'hFFFF);
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; mode = 1'b0; count = 16'd0;
        fault_and_s0 = 1'b0; fault_mux0 = 1'b0; fault_dff0 = 1'b0; fault_dff1 = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rstn = 1'b1;

        // Counter mode, N=16, ideal responses.
        run(1'b0, 16'd16);
        check("c16_busy_cycles", 32'(busy_cycles), 32'd17);
        for (int i = 0; i < 16; i++)
            check($sformatf("c16_stim%0d", i), 32'(stim_log[i]), 32'(i));
        check("c16_done", 32'(done), 32'd1);
        check("c16_pass", 32'(pass), 32'd1);
        check("c16_err",  32'(err_cnt), 32'd0);
        check("c16_ff",   32'(first_fail), 32'hFFFF);
        check("c16_stim_hold", 32'(stim), 32'd15);
        repeat (3) @(negedge clk);
        check("c16_done_hold", 32'(done), 32'd1);

        // Mux output stuck 0: the mux uses bits 7..9, all zero for k<8, so N=8 is clean.
        fault_mux0 = 1'b1;
        run(1'b0, 16'd8);
        check("mux8_err",  32'(err_cnt), 32'd0);
        check("mux8_pass", 32'(pass), 32'd1);
        // For k<400 only 0x180..0x18F have s7=s8=1; s7=0,s9=1 needs k>=512.
        run(1'b0, 16'd400);
        check("mux400_err",  32'(err_cnt), 32'd16);
        check("mux400_ff",   32'(first_fail), 32'd384);
        check("mux400_pass", 32'(pass), 32'd0);
        fault_mux0 = 1'b0;

        // LFSR mode, N=3: 0xACE1 -> 0x5670 -> 0xAB38.
        run(1'b1, 16'd3);
        check("lfsr_busy_cycles", 32'(busy_cycles), 32'd4);
        check("lfsr_stim0", 32'(stim_log[0]), 32'h0CE1);
        check("lfsr_stim1", 32'(stim_log[1]), 32'h1670);
        check("lfsr_stim2", 32'(stim_log[2]), 32'h0B38);
        check("lfsr_pass",  32'(pass), 32'd1);

        // Combinational and dff failures on the same edge: lower index wins.
        fault_and_s0 = 1'b1; fault_dff1 = 1'b1;
        run(1'b0, 16'd2);
        check("both_err",  32'(err_cnt), 32'd2);
        check("both_ff",   32'(first_fail), 32'd0);
        check("both_pass", 32'(pass), 32'd0);
        fault_and_s0 = 1'b0; fault_dff1 = 1'b0;

        // dff stuck 0, N=8193: vectors 4096..8191 fail, vector 8192 wraps to 0.
        fault_dff0 = 1'b1;
        run(1'b0, 16'd8193);
        check("wrap_busy_cycles", 32'(busy_cycles), 32'd8194);
        check("wrap_err",  32'(err_cnt), 32'd255);
        check("wrap_ff",   32'(first_fail), 32'd4096);
        check("wrap_pass", 32'(pass), 32'd0);
        check("wrap_stim", 32'(stim), 32'h0000);
        fault_dff0 = 1'b0;

        // N=0 goes straight to DONE and clears the previous result.
        run(1'b0, 16'd0);
        check("n0_busy_cycles", 32'(busy_cycles), 32'd0);
        check("n0_done", 32'(done), 32'd1);
        check("n0_pass", 32'(pass), 32'd1);
        check("n0_stim", 32'(stim), 32'd0);
        check("n0_err",  32'(err_cnt), 32'd0);
        check("n0_ff",   32'(first_fail), 32'hFFFF);

        // N=100 with dff stuck 1; start during RUN ignored; reset at k=5.
        fault_dff1 = 1'b1;
        @(negedge clk);
        mode = 1'b0; count = 16'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                start = 1'b1; count = 16'd0; mode = 1'b1;
            end
            if (k == 3) begin
                start = 1'b0;
                check("ign_stim", 32'(stim), 32'd3);
                check("ign_busy", 32'(busy), 32'd1);
            end
            @(negedge clk);
        end
        check("abort_stim_k5", 32'(stim), 32'd5);
        check("abort_err_k5",  32'(err_cnt), 32'd4);
        rstn = 1'b0; start = 1'b1; count = 16'd3; mode = 1'b0;
        @(negedge clk);
        check_reset_state("abort");
        @(negedge clk);
        check_reset_state("abort_hold");
        start = 1'b0; rstn = 1'b1; fault_dff1 = 1'b0;
        $display("run abort at k=5 err=%0d first_fail=%0h busy=%0d", err_cnt, first_fail, busy);

        run(1'b0, 16'd4);
        check("post_busy_cycles", 32'(busy_cycles), 32'd5);
        check("post_stim3", 32'(stim_log[3]), 32'd3);
        check("post_pass", 32'(pass), 32'd1);
        check("post_err",  32'(err_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
